multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Drives the 3-bit ALUOp consumed by the ALU controller: 000 = R-type/funct, 010 = add, 110 = sub, 111 = slti.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- opcode_i  in  6  IR[31:26], valid from DECODE onward
- mem_ready_i  in  1  memory completes the current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero (beq)
- i_or_d_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  load IR
- mem_to_reg_o  out  1  1 = MDR to register file
- reg_dst_o  out  1  1 = rd, 0 = rt
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  0 = PC, 1 = A
- alu_src_b_o  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op_o  out  3  to ALU controller
- pc_source_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- instr_done_o  out  1  one-cycle pulse on the final cycle of an instruction
- illegal_op_o  out  1  one-cycle pulse, unknown opcode in DECODE
- retired_cnt_o  out  CNT_W  count of instr_done_o pulses
- state_o  out  4  current state, for debug

Behaviour:
- Clock and reset: clk_i only; rst_i is synchronous and active-high.
- Reset: state = FETCH, retired_cnt_o = 0. All outputs then take the FETCH values:
  - mem_read_o = 1, alu_src_b_o = 01, alu_op_o = 010.
  - All other outputs 0; pc_write_o and ir_write_o = 0 until mem_ready_i = 1.
  - Reset has priority over every transition, including a stalled memory access.
- Outputs are decoded from the state register only. Exception: pc_write_o and ir_write_o in FETCH are additionally gated by mem_ready_i.
- States and encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5
  - EXEC = 6, R_WB = 7, BRANCH = 8, ADDI_EX = 9, SLTI_EX = 10, IMM_WB = 11, JUMP = 12
  - Encodings 13–15 are unreachable and recover to FETCH.
- FETCH: outputs as at reset; pc_source_o = 00. Stay while mem_ready_i = 0. When it is 1, assert pc_write_o and ir_write_o, go to DECODE.
- DECODE: alu_src_a_o = 0, alu_src_b_o = 11, alu_op_o = 010 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDI_EX
  - 001010 (slti) -> SLTI_EX
  - 000010 (j) -> JUMP, only with the optional feature
  - any other opcode -> illegal_op_o = 1, instr_done_o = 0, go to FETCH
- MEM_ADDR: alu_src_a_o = 1, alu_src_b_o = 10, alu_op_o = 010. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read_o = 1, i_or_d_o = 1. Hold until mem_ready_i = 1, then MEM_WB.
- MEM_WB: reg_write_o = 1, mem_to_reg_o = 1, reg_dst_o = 0, instr_done_o = 1 -> FETCH.
- MEM_WR: mem_write_o = 1, i_or_d_o = 1. Hold until mem_ready_i = 1; in that cycle instr_done_o = 1 -> FETCH.
- EXEC: alu_src_a_o = 1, alu_src_b_o = 00, alu_op_o = 000 -> R_WB.
- R_WB: reg_write_o = 1, reg_dst_o = 1, mem_to_reg_o = 0, instr_done_o = 1 -> FETCH.
- BRANCH: alu_src_a_o = 1, alu_src_b_o = 00, alu_op_o = 110, pc_write_cond_o = 1, pc_source_o = 01, instr_done_o = 1 -> FETCH.
- ADDI_EX: alu_src_a_o = 1, alu_src_b_o = 10, alu_op_o = 010 -> IMM_WB.
- SLTI_EX: alu_src_a_o = 1, alu_src_b_o = 10, alu_op_o = 111 -> IMM_WB.
- IMM_WB: reg_write_o = 1, reg_dst_o = 0, mem_to_reg_o = 0, instr_done_o = 1 -> FETCH.
- retired_cnt_o increments on every cycle with instr_done_o = 1 and wraps modulo 2^CNT_W, with no saturation.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR. mem_read_o / mem_write_o hold steady while stalled.

Optional Feature:
- Macro: MULTICYCLE_CTRL_JUMP_EN.
- Defined: opcode 000010 goes to JUMP. JUMP asserts pc_write_o = 1, pc_source_o = 10, instr_done_o = 1 -> FETCH.
- Undefined: JUMP is absent and 000010 is treated as illegal.

Decomposition:
- Shared package holds:
  - state enum and encodings
  - opcode constants
  - ALUOp constants: ALUOP_RTYPE = 000, ALUOP_ADD = 010, ALUOP_SUB = 110, ALUOP_SLT = 111
  - alu_src_b / pc_source encodings
- One sub-module, ctrl_retire_counter: the CNT_W counter with synchronous reset and an increment enable.

Test Plan:
- Reset held 2 cycles, mem_ready_i = 1 -> state_o = 0, mem_read_o = 1, alu_op_o = 010, retired_cnt_o = 0. pc_write_o = 1 on the first cycle after release.
- lw (100011), mem_ready_i low 3 cycles in MEM_RD -> state sequence 0, 1, 2, 3, 3, 3, 3, 4, 0. reg_write_o = 1 and mem_to_reg_o = 1 only in state 4. retired_cnt_o = 1.
- R-type then slti -> alu_op_o = 000 in EXEC, 111 in SLTI_EX. reg_dst_o = 1 in R_WB, 0 in IMM_WB. retired_cnt_o = 2.
- beq (000100) -> BRANCH has pc_write_cond_o = 1, alu_op_o = 110, pc_source_o = 01. Takes 3 cycles total.
- Opcode 111111 -> illegal_op_o pulses for 1 cycle in DECODE, next state FETCH, retired_cnt_o unchanged. Repeat with 000010: illegal without the macro; with the macro, JUMP sets pc_source_o = 10.
- rst_i asserted during a MEM_WR stall -> next state FETCH, mem_write_o = 0, retired_cnt_o = 0. Counter preloaded to all ones then one retire -> wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// MULTICYCLE_CTRL_JUMP_EN enables decoding of j (000010) into the JUMP state.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_SLTI_EX  = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_SLT   = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FETCH as a target means the opcode is not recognised.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t nxt;
        unique case (1'b1)
            (op == OP_LW),
            (op == OP_SW):    nxt = S_MEM_ADDR;
            (op == OP_RTYPE): nxt = S_EXEC;
            (op == OP_BEQ):   nxt = S_BRANCH;
            (op == OP_ADDI):  nxt = S_ADDI_EX;
            (op == OP_SLTI):  nxt = S_SLTI_EX;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            (op == OP_J):     nxt = S_JUMP;
`else
            (op == OP_J):     nxt = S_FETCH;
`endif
            default:          nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_retire_counter.sv
// Retired-instruction counter: synchronous reset, wraps modulo 2^CNT_W.
module ctrl_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + ONE;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Build with MULTICYCLE_CTRL_JUMP_EN to support the j instruction.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic             instr_done_o,
    output logic             illegal_op_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [3:0]       state_o
);

    import multicycle_ctrl_pkg::*;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE:   state_nxt = decode_target(opcode_i);
            S_MEM_ADDR: state_nxt = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_nxt = S_FETCH;
            S_MEM_WR:   state_nxt = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_nxt = S_R_WB;
            S_R_WB:     state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_ADDI_EX:  state_nxt = S_IMM_WB;
            S_SLTI_EX:  state_nxt = S_IMM_WB;
            S_IMM_WB:   state_nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP:     state_nxt = S_FETCH;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        alu_op_o        = ALUOP_RTYPE;
        pc_source_o     = PCSRC_ALU;
        instr_done_o    = 1'b0;
        illegal_op_o    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALUOP_ADD;
                pc_write_o  = mem_ready_i;
                ir_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o  = SRCB_IMM_SH;
                alu_op_o     = ALUOP_ADD;
                illegal_op_o = (decode_target(opcode_i) == S_FETCH);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                instr_done_o    = 1'b1;
            end
            S_SLTI_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_SLT;
            end
            S_IMM_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = PCSRC_JUMP;
                instr_done_o = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state_o = state;

    ctrl_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(instr_done_o),
        .cnt_o(retired_cnt_o)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cycle table,
// counter wrap sequence and random instruction streams vs. a cycle-plan model.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic          clk;
    logic          rst;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic [1:0]    pc_source;
    logic          instr_done, illegal_op;
    logic [CW-1:0] retired_cnt;
    logic [3:0]    state;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .opcode_i(opcode),
        .mem_ready_i(mem_ready),
        .pc_write_o(pc_write),
        .pc_write_cond_o(pc_write_cond),
        .i_or_d_o(i_or_d),
        .mem_read_o(mem_read),
        .mem_write_o(mem_write),
        .ir_write_o(ir_write),
        .mem_to_reg_o(mem_to_reg),
        .reg_dst_o(reg_dst),
        .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op),
        .pc_source_o(pc_source),
        .instr_done_o(instr_done),
        .illegal_op_o(illegal_op),
        .retired_cnt_o(retired_cnt),
        .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
        logic       ill;
    } ctl_t;

    typedef struct {
        bit         rst;
        logic [5:0] op;
        bit         rdy;
        int         st;
        int         cnt;
    } vec_t;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt;
    vec_t tbl[$];

    function automatic bit is_legal(input logic [5:0] op);
        if (op == LW || op == SW || op == RT || op == BEQ) return 1'b1;
        if (op == ADDI || op == SLTI) return 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        if (op == JMP) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Required control word for each state, taken from the state table.
    function automatic ctl_t spec_out(input int st, input bit rdy,
                                      input logic [5:0] op);
        ctl_t e = '0;
        case (st)
            0:  begin e.mrd = 1; e.srcb = 2'b01; e.aluop = 3'b010;
                      e.pcw = rdy; e.irw = rdy; end
            1:  begin e.srcb = 2'b11; e.aluop = 3'b010;
                      e.ill = !is_legal(op); end
            2:  begin e.srca = 1; e.srcb = 2'b10; e.aluop = 3'b010; end
            3:  begin e.mrd = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
            5:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            6:  begin e.srca = 1; e.srcb = 2'b00; e.aluop = 3'b000; end
            7:  begin e.rw = 1; e.rdst = 1; e.done = 1; end
            8:  begin e.srca = 1; e.aluop = 3'b110; e.pcwc = 1;
                      e.pcsrc = 2'b01; e.done = 1; end
            9:  begin e.srca = 1; e.srcb = 2'b10; e.aluop = 3'b010; end
            10: begin e.srca = 1; e.srcb = 2'b10; e.aluop = 3'b111; end
            11: begin e.rw = 1; e.done = 1; end
            12: begin e.pcw = 1; e.pcsrc = 2'b10; e.done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int st, input bit rdy,
                               input logic [5:0] op, input int cnt);
        ctl_t a;
        ctl_t e;
        a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, illegal_op};
        e = spec_out(st, rdy, op);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " ctl"}, 32'(a), 32'(e));
        check({tag, " cnt"}, 32'(retired_cnt), 32'(cnt));
    endtask

    task automatic add(input bit r, input logic [5:0] op, input bit rdy,
                       input int st, input int cnt);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // Expand one instruction into its cycle plan from the spec rules.
    task automatic run_instr(input logic [5:0] op, input int fstall,
                             input int mstall);
        step_t plan[$];
        logic [31:0] r;
        ctl_t e;
        for (int i = 0; i < fstall; i++) plan.push_back('{0, 1'b0});
        plan.push_back('{0, 1'b1});
        plan.push_back('{1, 1'($urandom_range(0, 1))});
        if (op == LW || op == SW) begin
            plan.push_back('{2, 1'($urandom_range(0, 1))});
            for (int i = 0; i < mstall; i++)
                plan.push_back('{(op == LW) ? 3 : 5, 1'b0});
            plan.push_back('{(op == LW) ? 3 : 5, 1'b1});
            if (op == LW) plan.push_back('{4, 1'($urandom_range(0, 1))});
        end else if (op == RT) begin
            plan.push_back('{6, 1'($urandom_range(0, 1))});
            plan.push_back('{7, 1'($urandom_range(0, 1))});
        end else if (op == BEQ) begin
            plan.push_back('{8, 1'($urandom_range(0, 1))});
        end else if (op == ADDI || op == SLTI) begin
            plan.push_back('{(op == ADDI) ? 9 : 10, 1'($urandom_range(0, 1))});
            plan.push_back('{11, 1'($urandom_range(0, 1))});
        end else if (is_legal(op)) begin
            plan.push_back('{12, 1'($urandom_range(0, 1))});
        end
        foreach (plan[k]) begin
            rst = 1'b0;
            mem_ready = plan[k].rdy;
            if (plan[k].st == 0) begin
                r = $urandom();
                opcode = r[5:0];
            end else begin
                opcode = op;
            end
            @(negedge clk);
            check_cycle("instr", plan[k].st, plan[k].rdy, opcode, model_cnt);
            e = spec_out(plan[k].st, plan[k].rdy, opcode);
            @(posedge clk);
            #1;
            if (e.done) model_cnt = (model_cnt + 1) % (1 << CW);
        end
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [31:0] r;
        logic [5:0] op;
        int c;

        rst = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        add(1, RT, 1, 0, 0);
        add(1, RT, 1, 0, 0);
        add(0, LW, 1, 0, 0);
        add(0, LW, 0, 1, 0);
        add(0, LW, 1, 2, 0);
        add(0, LW, 0, 3, 0);
        add(0, LW, 0, 3, 0);
        add(0, LW, 0, 3, 0);
        add(0, LW, 1, 3, 0);
        add(0, LW, 0, 4, 0);
        add(0, RT, 1, 0, 1);
        add(0, RT, 0, 1, 1);
        add(0, RT, 1, 6, 1);
        add(0, RT, 0, 7, 1);
        add(0, SLTI, 1, 0, 2);
        add(0, SLTI, 0, 1, 2);
        add(0, SLTI, 1, 10, 2);
        add(0, SLTI, 0, 11, 2);
        add(0, BEQ, 1, 0, 3);
        add(0, BEQ, 0, 1, 3);
        add(0, BEQ, 1, 8, 3);
        add(0, BAD, 1, 0, 4);
        add(0, BAD, 0, 1, 4);
        add(0, JMP, 0, 0, 4);
        add(0, JMP, 1, 0, 4);
        add(0, JMP, 1, 1, 4);
        c = 4;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        add(0, JMP, 0, 12, 4);
        c = 5;
`endif
        add(0, SW, 1, 0, c);
        add(0, SW, 1, 1, c);
        add(0, SW, 0, 2, c);
        add(0, SW, 0, 5, c);
        add(0, SW, 0, 5, c);
        add(1, SW, 0, 5, c);
        add(0, ADDI, 1, 0, 0);
        add(0, ADDI, 0, 1, 0);
        add(0, ADDI, 1, 9, 0);
        add(0, ADDI, 0, 11, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            opcode = tbl[i].op;
            mem_ready = tbl[i].rdy;
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), tbl[i].st, tbl[i].rdy,
                        tbl[i].op, tbl[i].cnt);
            @(posedge clk);
            #1;
        end
        model_cnt = 1;

        // Counter wrap: bring the count to all ones, then retire once more.
        for (int i = 0; i < 14; i++) run_instr(RT, 0, 0);
        check("cnt all ones", 32'(retired_cnt), 32'(15));
        run_instr(ADDI, 1, 0);
        check("cnt wrap", 32'(retired_cnt), 32'(0));

        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
        ops[4] = ADDI; ops[5] = SLTI; ops[6] = JMP; ops[7] = BAD;
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom();
                op = r[5:0];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
